mem_req_ctrl: RTL and testbench

Memory-stage request controller. It sits between the EX/MEM latch outputs and the data-cache port, and is the producer side of the MEM/WB latch. It issues registered dREN/dWEN requests, waits for dhit, and captures load data. It drives the MEM/WB enable/flush and the pipeline stall, and parks the pipeline on halt.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/mem_req_ctrl_sat_counter.sv | 22 ++
 rtl/mem_req_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_req_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word and the memory-stage request controller state/limits.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Memory-stage request controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } memctl_state_t;

  localparam int unsigned MEMCTL_STALL_CNT_W   = 32;
  localparam logic [MEMCTL_STALL_CNT_W-1:0] MEMCTL_STALL_CNT_MAX = '1;

endpackage

// File: rtl/mem_req_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter #(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc until MAX; reset and clr both return to zero
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory-stage request controller: drives registered dmemREN/dmemWEN to the data
// cache, waits for dhit, captures load data and steers MEM/WB enable/flush and the
// pipeline stall. Optional request watchdog enabled by MEM_REQ_TIMEOUT_EN.
module mem_req_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef MEM_REQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              exmem_valid,
  input  logic              exmem_dREN,
  input  logic              exmem_dWEN,
  input  logic              exmem_halt,
  input  logic [ADDR_W-1:0] exmem_addr,
  input  logic [DATA_W-1:0] exmem_store,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dmemload_o,
  output logic              memwb_en,
  output logic              memwb_flush,
  output logic              stall_o,
  output logic              halted,
  output logic [31:0]       stall_cnt,
  output logic              timeout_err
);

  memctl_state_t     state, state_n;
  logic              mem_op;
  logic              start_req;
  logic              req_done;
  logic [DATA_W-1:0] load_q;

  assign mem_op     = exmem_valid & (exmem_dREN | exmem_dWEN);
  assign dmemload_o = load_q;

  // Next-state and pipeline control; halt wins over a (illegal) concurrent mem op
  always_comb begin
    state_n     = state;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    stall_o     = 1'b0;
    start_req   = 1'b0;
    req_done    = 1'b0;
    case (state)
      IDLE: begin
        if (!exmem_valid) begin
          memwb_flush = 1'b1;
        end else if (exmem_halt) begin
          memwb_en = 1'b1;
          state_n  = HALT;
        end else if (mem_op) begin
          stall_o   = 1'b1;
          start_req = 1'b1;
          state_n   = REQ;
        end else begin
          memwb_en = 1'b1;
        end
      end
      REQ: begin
        stall_o = 1'b1;
        if (dhit) begin
          req_done = 1'b1;
          state_n  = DONE;
        end
      end
      DONE: begin
        memwb_en = 1'b1;
        state_n  = IDLE;
      end
      HALT: begin
        stall_o = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, cache request registers, load capture and halt flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      load_q    <= '0;
      halted    <= 1'b0;
    end else begin
      state <= state_n;
      if (start_req) begin
        dmemREN   <= exmem_dREN & ~exmem_dWEN;
        dmemWEN   <= exmem_dWEN;
        dmemaddr  <= exmem_addr;
        dmemstore <= exmem_store;
      end
      if (req_done) begin
        dmemREN <= 1'b0;
        dmemWEN <= 1'b0;
        if (dmemREN) begin
          load_q <= dmemload;
        end
      end
      if (state_n == HALT) begin
        halted <= 1'b1;
      end
    end
  end

  // Cycles spent with the pipeline frozen
  sat_counter #(
    .WIDTH (MEMCTL_STALL_CNT_W),
    .MAX   (MEMCTL_STALL_CNT_MAX)
  ) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (1'b0),
    .inc   (stall_o),
    .count (stall_cnt)
  );

`ifdef MEM_REQ_TIMEOUT_EN
  logic        wait_inc;
  logic [31:0] wait_cnt;

  assign wait_inc = (state == REQ) & ~dhit;

  // Wait cycles of the current request; restarts each time a request is issued
  sat_counter #(
    .WIDTH (32),
    .MAX   (32'hFFFF_FFFF)
  ) u_wait_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (start_req),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

  // Sticky flag set on the edge where the wait count reaches TIMEOUT_CYCLES
  always_ff @(posedge CLK) begin
    if (RST) begin
      timeout_err <= 1'b0;
    end else if (wait_inc && (wait_cnt >= 32'(TIMEOUT_CYCLES - 1))) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: an instruction-level model expands each
// instruction into its per-cycle expected outputs; a monitor compares at negedge.
module tb_mem_req_ctrl;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int T_LIMIT = 8;
`else
  localparam int T_LIMIT = 1 << 30;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        exmem_valid, exmem_dREN, exmem_dWEN, exmem_halt;
  logic [31:0] exmem_addr, exmem_store;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload_o;
  logic        memwb_en, memwb_flush, stall_o, halted, timeout_err;
  logic [31:0] stall_cnt;

  always #5 CLK = ~CLK;

  mem_req_ctrl #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef MEM_REQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES (T_LIMIT)
`endif
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .exmem_valid (exmem_valid),
    .exmem_dREN  (exmem_dREN),
    .exmem_dWEN  (exmem_dWEN),
    .exmem_halt  (exmem_halt),
    .exmem_addr  (exmem_addr),
    .exmem_store (exmem_store),
    .dhit        (dhit),
    .dmemload    (dmemload),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .dmemaddr    (dmemaddr),
    .dmemstore   (dmemstore),
    .dmemload_o  (dmemload_o),
    .memwb_en    (memwb_en),
    .memwb_flush (memwb_flush),
    .stall_o     (stall_o),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        en, flush, stall, ren, wen, hlt, terr, chk_addr;
    logic [31:0] addr, store, load, scnt;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (instruction-level)
  logic [31:0] m_scnt;
  logic [31:0] m_load;
  logic        m_terr;
  logic        m_halt;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endfunction

  // Monitor: compare one expected cycle per falling edge
  always @(negedge CLK) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("memwb_en",    32'(memwb_en),    32'(e.en));
      chk("memwb_flush", 32'(memwb_flush), 32'(e.flush));
      chk("stall_o",     32'(stall_o),     32'(e.stall));
      chk("dmemREN",     32'(dmemREN),     32'(e.ren));
      chk("dmemWEN",     32'(dmemWEN),     32'(e.wen));
      chk("halted",      32'(halted),      32'(e.hlt));
      chk("timeout_err", 32'(timeout_err), 32'(e.terr));
      chk("dmemload_o",  dmemload_o,       e.load);
      chk("stall_cnt",   stall_cnt,        e.scnt);
      if (e.chk_addr) begin
        chk("dmemaddr",  dmemaddr,  e.addr);
        chk("dmemstore", dmemstore, e.store);
      end
    end
  end

  task automatic drive(input logic v, input logic r, input logic w, input logic h,
                       input logic [31:0] a, input logic [31:0] s,
                       input logic dh, input logic [31:0] ld);
    exmem_valid = v;
    exmem_dREN  = r;
    exmem_dWEN  = w;
    exmem_halt  = h;
    exmem_addr  = a;
    exmem_store = s;
    dhit        = dh;
    dmemload    = ld;
  endtask

  // Push this cycle's expectation, advance the model's stall count, step one clock
  task automatic expect_cycle(input logic en, input logic fl, input logic st,
                              input logic rn, input logic wn, input logic ca,
                              input logic [31:0] a, input logic [31:0] s);
    exp_t e;
    e.en = en; e.flush = fl; e.stall = st; e.ren = rn; e.wen = wn;
    e.hlt = m_halt; e.terr = m_terr; e.chk_addr = ca;
    e.addr = a; e.store = s; e.load = m_load; e.scnt = m_scnt;
    expq.push_back(e);
    if (st && (m_scnt != 32'hFFFF_FFFF)) m_scnt = m_scnt + 32'd1;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_scnt = '0; m_load = '0; m_terr = 1'b0; m_halt = 1'b0;
  endtask

  task automatic do_bubble();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom());
    expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_alu();
    drive(1'b1, 1'b0, 1'b0, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom());
    expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Memory op: 1 issue cycle, w wait cycles + 1 hit cycle, 1 completion cycle
  task automatic do_mem(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] s, input int waits, input logic [31:0] ld);
    logic is_ld;
    is_ld = r & ~w;
    drive(1'b1, r, w, 1'b0, a, s, 1'($urandom_range(0, 1)), $urandom());
    expect_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int k = 1; k <= waits + 1; k++) begin
      dhit     = (k == waits + 1);
      dmemload = (k == waits + 1) ? ld : $urandom();
      expect_cycle(1'b0, 1'b0, 1'b1, is_ld, ~is_ld, 1'b1, a, s);
      if ((k <= waits) && (k >= T_LIMIT)) m_terr = 1'b1;
    end
    if (is_ld) m_load = ld;
    dhit     = 1'($urandom_range(0, 1));
    dmemload = $urandom();
    expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_rand_mem();
    logic r, w;
    int   waits;
    r = 1'($urandom_range(0, 1));
    w = r ? 1'($urandom_range(0, 1)) : 1'b1;
    waits = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
    do_mem(r, w, $urandom(), $urandom(), waits, $urandom());
  endtask

  initial begin
    model_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset state seen through a bubble cycle
    do_bubble();

    // Directed: load with first-cycle hit, store with 4 waits, ADD/load/ADD
    do_mem(1'b1, 1'b0, 32'h0000_0100, $urandom(), 0, 32'hDEAD_BEEF);
    do_mem(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4, $urandom());
    do_alu();
    do_mem(1'b1, 1'b0, $urandom(), $urandom(), 0, $urandom());
    do_alu();
    do_mem(1'b1, 1'b1, $urandom(), $urandom(), 1, $urandom());

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0, 1:       do_bubble();
        2, 3, 4:    do_alu();
        default:    do_rand_mem();
      endcase
    end
    do_mem(1'b0, 1'b1, $urandom(), $urandom(), 9, $urandom());

    // Reset in the second REQ cycle; a stale dhit afterwards is ignored
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, $urandom(), 1'b0, $urandom());
    expect_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    expect_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    RST = 1'b1;
    expect_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    model_reset();
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 32'hBAD0_BAD0);
    expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    do_mem(1'b1, 1'b0, $urandom(), $urandom(), 2, $urandom());

    // Halt (with a concurrent load request bit), then parked forever
    drive(1'b1, 1'b1, 1'b0, 1'b1, $urandom(), $urandom(), 1'b0, $urandom());
    expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    m_halt = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom());
      expect_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    end

    // Only reset leaves HALT
    RST = 1'b1;
    expect_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    model_reset();
    RST = 1'b0;
    do_bubble();
    do_alu();

    // Drain: every expectation must have been consumed by the monitor
    @(posedge CLK);
    #1;
    n_checks++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
